// File: rtl/arb_pkg.sv
// Shared types and constants for the L2 bus arbiter.
//   arb_state_t : arbiter FSM state encoding
//   OWNER_*     : encoding of the 2-bit owner / last-owner / winner values
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT1  = 2'd1,
    ARB_GRANT2  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_C1   = 2'd1;
  localparam logic [1:0] OWNER_C2   = 2'd2;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection for the two-core L2 bus arbiter.
// Ports:
//   req1_i, req2_i     : core requests
//   flush1_i, flush2_i : write-back pending (raises priority)
//   last_owner_i       : core granted most recently (OWNER_C1 / OWNER_C2)
//   winner_o           : OWNER_NONE, OWNER_C1 or OWNER_C2
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic       req1_i,
  input  logic       req2_i,
  input  logic       flush1_i,
  input  logic       flush2_i,
  input  logic [1:0] last_owner_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = OWNER_NONE;
    if (req1_i && req2_i) begin
      // A single pending flush wins; otherwise alternate away from last owner.
      if (flush1_i != flush2_i) begin
        winner_o = flush1_i ? OWNER_C1 : OWNER_C2;
      end else begin
        winner_o = (last_owner_i == OWNER_C1) ? OWNER_C2 : OWNER_C1;
      end
    end else if (req1_i) begin
      winner_o = OWNER_C1;
    end else if (req2_i) begin
      winner_o = OWNER_C2;
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Two-core L2 bus arbiter with flush priority and round-robin tie-break.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_core1/2              : core bus requests
//   flush_in1/2              : core write-back pending (priority boost)
//   l2_done                  : L2 transaction complete
//   grant_core1/2            : registered grants, one-hot or zero
//   stall_core1/2            : request & ~grant
//   owner                    : 0 none, 1 core1, 2 core2
//   timeout_err              : one-cycle pulse on forced release (0 if disabled)
module l2_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_core1,
  input  logic       req_core2,
  input  logic       flush_in1,
  input  logic       flush_in2,
  input  logic       l2_done,
  output logic       grant_core1,
  output logic       grant_core2,
  output logic       stall_core1,
  output logic       stall_core2,
  output logic [1:0] owner,
  output logic       timeout_err
);

  arb_state_t state_q;
  logic       grant1_q, grant2_q;
  logic [1:0] owner_q, last_owner_q;
  logic [1:0] winner;
  logic       cur_req;
  logic       to_hit;

  arb_rr_pick u_pick (
    .req1_i       (req_core1),
    .req2_i       (req_core2),
    .flush1_i     (flush_in1),
    .flush2_i     (flush_in2),
    .last_owner_i (last_owner_q),
    .winner_o     (winner)
  );

  assign cur_req = (state_q == ARB_GRANT1) ? req_core1 : req_core2;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          terr_q;

  assign to_hit      = (cnt_q == CNT_LAST);
  assign timeout_err = terr_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant1_q     <= 1'b0;
      grant2_q     <= 1'b0;
      owner_q      <= OWNER_NONE;
      last_owner_q <= OWNER_C2;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      terr_q       <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      terr_q <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (winner != OWNER_NONE) begin
            state_q      <= (winner == OWNER_C1) ? ARB_GRANT1 : ARB_GRANT2;
            grant1_q     <= (winner == OWNER_C1);
            grant2_q     <= (winner == OWNER_C2);
            owner_q      <= winner;
            last_owner_q <= winner;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
          end
        end
        ARB_GRANT1, ARB_GRANT2: begin
          if (l2_done || !cur_req || to_hit) begin
            state_q  <= ARB_RELEASE;
            grant1_q <= 1'b0;
            grant2_q <= 1'b0;
            owner_q  <= OWNER_NONE;
`ifdef ARB_TIMEOUT_EN
            // Error only when the timeout alone forced the release.
            terr_q   <= !(l2_done || !cur_req);
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_q <= cnt_q + CW'(1);
`endif
          end
        end
        ARB_RELEASE: state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant_core1 = grant1_q;
  assign grant_core2 = grant2_q;
  assign owner       = owner_q;
  assign stall_core1 = req_core1 & ~grant1_q;
  assign stall_core2 = req_core2 & ~grant2_q;

endmodule
